weighted_rr_arbiter: RTL
========================

# weighted_rr_arbiter

Weighted round-robin arbiter with registered one-hot grant, per-requester burst weights and lock/hold support. It sits in front of shared resources such as a memory port, bus master mux or response channel. Each winner holds the grant for a programmable number of cycles or while it asserts lock, then priority rotates to the next requester. Successor to the single-cycle rotating-mask arbiter, adding multi-cycle bursts, lock and a release indication.

## Interface
- NumRequests, 8: number of requesters, ≥2.
- WeightWidth, 4: width of each per-requester weight.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when low, all state holds.
- req  in  NumRequests  request vector.
- lock  in  NumRequests  lock[i] extends the burst of owner i indefinitely.
- weight  in  NumRequests×WeightWidth  burst length minus one per requester, packed as [i*WeightWidth +: WeightWidth].
- grant  out  NumRequests  registered one-hot grant, zero when idle.
- grant_enc  out  $clog2(NumRequests)+1  binary index of owner; all ones when idle.
- last  out  1  registered; high on the final cycle of the current burst.

## Operation
- States are IDLE (no owner) and GRANT (owner valid).
- A rotating priority pointer ptr is a one-hot mask. The search starts at ptr, scans upward and wraps. Reset value of ptr is bit 0.
- IDLE, req≠0: pick the first requester at or above ptr (wrapping), then grant it. Load cnt ← weight[owner] and go to GRANT.
- GRANT, owner keeps the grant while req[owner] && (cnt≠0 || lock[owner]). Each kept cycle, cnt decrements if cnt≠0. cnt saturates at 0 while locked.
- Release occurs when req[owner]=0, or cnt=0 && !lock[owner]. On release, ptr ← the bit above owner (wrapping). The next owner is picked in the same cycle from the current req using the new ptr, with no idle bubble.
  - If the released owner is the only requester, it is re-granted with cnt reloaded.
  - If req is empty after masking, go to IDLE.
- A weight change during a burst has no effect until the next grant load.
- last = registered (cnt==0 && !lock[owner]) for the current owner. last is also high for a weight-0 grant in its only cycle. last is 0 in IDLE.
- Invariants:
  - grant is always zero or one-hot.
  - grant_enc is consistent with grant.
  - A requester holding req continuously is granted within (NumRequests−1)×(2^WeightWidth) cycles, ignoring lock.

## Timing
- Reset: grant=0, grant_enc=all ones, last=0, state IDLE, cnt=0, ptr=bit 0.
- Reset has priority over ce.
- Latency: req rising at edge t (IDLE) gives grant at edge t+1.
- An owner with weight w, req held and no lock owns exactly w+1 consecutive ce cycles.
- A handover is back-to-back: the cycle after the release cycle shows the new grant.
- A req[owner] drop is seen at the next edge: grant moves or clears one cycle after the drop.
- A reset mid-burst aborts immediately; no partial state survives.
- ce low: grant, grant_enc, last, cnt and ptr hold. Inputs are ignored.

## Structure
- Package weighted_rr_arbiter_pkg holds:
  - arb_state_t enum {IDLE, GRANT}
  - function that builds the no-grant encoding (all ones of width $clog2(N)+1)
- Next-owner selection reuses the existing fixed-priority Arbiter module twice, once on the masked request and once on the unmasked request. The masked result wins when it is non-zero.
- One registered always_ff holds state, cnt, ptr, grant, grant_enc and last. Next-state logic is combinational.

## Test plan
- Reset check: assert rst for 2 cycles with req=4'b1111 (N=4, W=2) → grant=0, grant_enc=3'b111, last=0. First grant after release is 4'b0001.
- Fair rotation: all weights=0, req=4'b0101 held → grant sequence 0001,0100,0001,0100 on consecutive cycles, last=1 every cycle.
- Burst: weight[1]=3, req=4'b0010 only → grant 0010 continuous, last high every 4th cycle, no gap between re-grants. Adding req[2] mid-burst → grant 0100 right after the burst's last cycle.
- Lock: owner 2, weight 0, lock[2]=1 for 5 cycles with req=4'b1111 → grant 0100 for 5 cycles, last=0 while locked, then grant 1000.
- Early drop: weight[0]=3, req=4'b0011, req[0] deasserted after 2 granted cycles → next cycle grant=0010, grant_enc=1.
- Clock enable and reset: ce low for 3 cycles mid-burst → outputs frozen and burst resumes with the remaining count. rst asserted while ce is low → all outputs take reset values at the next edge.

Source files
------------

// File: rtl/weighted_rr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package weighted_rr_arbiter_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    // All-ones index value reported while no requester owns the grant.
    function automatic logic [31:0] no_grant_enc(input int unsigned n);
        return (32'd1 << ($clog2(n) + 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/weighted_rr_arbiter_fp.sv
// Fixed-priority arbiter: the lowest-index active request wins.
module weighted_rr_arbiter_fp #(
    parameter int unsigned Width = 4
) (
    input  logic [Width-1:0] req_i,
    output logic [Width-1:0] gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < Width; i++) begin
            if (req_i[i] && !found) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter with burst weights, lock hold and a last-cycle flag.
module weighted_rr_arbiter
    import weighted_rr_arbiter_pkg::*;
#(
    parameter int unsigned NumRequests = 8,
    parameter int unsigned WeightWidth = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               ce_i,
    input  logic [NumRequests-1:0]             req_i,
    input  logic [NumRequests-1:0]             lock_i,
    input  logic [NumRequests*WeightWidth-1:0] weight_i,
    output logic [NumRequests-1:0]             grant_o,
    output logic [$clog2(NumRequests):0]       grant_enc_o,
    output logic                               last_o
);

    localparam int unsigned EncW = $clog2(NumRequests) + 1;
    localparam logic [EncW-1:0] NoGrant = EncW'(no_grant_enc(NumRequests));
    localparam logic [NumRequests-1:0] PtrOne = NumRequests'(1);
    localparam logic [WeightWidth-1:0] CntOne = WeightWidth'(1);

    arb_state_t             state_q, state_d;
    logic [WeightWidth-1:0] cnt_q, cnt_d;
    logic [NumRequests-1:0] ptr_q, ptr_d;
    logic [NumRequests-1:0] grant_q, grant_d;
    logic [EncW-1:0]        enc_q, enc_d;
    logic                   last_q, last_d;

    logic                   own_req, own_lock, keep;
    logic [NumRequests-1:0] rel_ptr, sel_ptr, req_masked;
    logic [NumRequests-1:0] pick_masked, pick_all, pick;
    logic [WeightWidth-1:0] pick_w, cnt_dec;
    logic [EncW-1:0]        pick_enc;
    logic                   pick_lock;

    assign own_req  = |(req_i & grant_q);
    assign own_lock = |(lock_i & grant_q);
    assign keep     = (state_q == GRANT) && own_req && ((cnt_q != '0) || own_lock);
    assign cnt_dec  = (cnt_q != '0) ? cnt_q - CntOne : '0;

    // On release the search starts just above the current owner, otherwise at ptr.
    assign rel_ptr    = {grant_q[NumRequests-2:0], grant_q[NumRequests-1]};
    assign sel_ptr    = (state_q == GRANT) ? rel_ptr : ptr_q;
    assign req_masked = req_i & ~(sel_ptr - PtrOne);

    weighted_rr_arbiter_fp #(
        .Width(NumRequests)
    ) u_fp_masked (
        .req_i(req_masked),
        .gnt_o(pick_masked)
    );

    weighted_rr_arbiter_fp #(
        .Width(NumRequests)
    ) u_fp_all (
        .req_i(req_i),
        .gnt_o(pick_all)
    );

    assign pick      = (pick_masked != '0) ? pick_masked : pick_all;
    assign pick_lock = |(lock_i & pick);

    always_comb begin
        pick_w   = '0;
        pick_enc = '0;
        for (int unsigned i = 0; i < NumRequests; i++) begin
            if (pick[i]) begin
                pick_w   = pick_w | weight_i[i*WeightWidth +: WeightWidth];
                pick_enc = EncW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        enc_d   = enc_q;
        last_d  = last_q;
        if (ce_i) begin
            if (keep) begin
                cnt_d  = cnt_dec;
                last_d = (cnt_dec == '0) && !own_lock;
            end else begin
                if (state_q == GRANT) begin
                    ptr_d = rel_ptr;
                end
                if (pick != '0) begin
                    state_d = GRANT;
                    grant_d = pick;
                    enc_d   = pick_enc;
                    cnt_d   = pick_w;
                    last_d  = (pick_w == '0) && !pick_lock;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    enc_d   = NoGrant;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= PtrOne;
            grant_q <= '0;
            enc_q   <= NoGrant;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            enc_q   <= enc_d;
            last_q  <= last_d;
        end
    end

    assign grant_o     = grant_q;
    assign grant_enc_o = enc_q;
    assign last_o      = last_q;

endmodule
